// File: rtl/decode_prefetch_queue.sv
// Byte-granular instruction prefetch queue feeding decode.
// Accepts 32-bit code words, presents an 8-byte window, advances by consumed count.
module decode_prefetch_queue #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic [1:0]      i_flush_offset,
  input  logic            i_fetch_valid,
  input  logic [31:0]     i_fetch_data,
  output logic            o_fetch_ready,
  output logic [7:0][7:0] o_window,
  output logic [3:0]      o_window_count,
  input  logic            i_consume_valid,
  input  logic [3:0]      i_consume,
  output logic [CW-1:0]   o_count,
  output logic            o_underrun
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    r_buf [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [1:0]    r_pend;
  logic          r_under;

  logic [3:0]    w_wcnt;
  logic          w_acc;
  logic [2:0]    w_push;
  logic          w_over;
  logic [3:0]    w_eff;
  logic [31:0]   w_shift;

  assign w_wcnt  = (r_count >= CW'(8)) ? 4'd8 : r_count[3:0];
  assign o_fetch_ready = (r_count <= CW'(DEPTH - 4));
  assign w_acc   = i_fetch_valid && o_fetch_ready && !i_flush;
  assign w_push  = w_acc ? (3'd4 - {1'b0, r_pend}) : 3'd0;
  assign w_over  = i_consume_valid && (i_consume > w_wcnt);
  assign w_eff   = !i_consume_valid ? 4'd0 :
                   w_over ? w_wcnt : i_consume;
  // Drop the bytes preceding an unaligned branch target.
  assign w_shift = i_fetch_data >> {r_pend, 3'b000};

  always_ff @(posedge i_clk) begin
    if (w_acc && !i_reset) begin
      for (int j = 0; j < 4; j++) begin
        if (3'(j) < w_push)
          r_buf[r_tail + PW'(j)] <= w_shift[8*j +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_pend  <= '0;
      r_under <= 1'b0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_pend  <= i_flush_offset;
      r_under <= 1'b0;
    end else begin
      r_head  <= r_head + PW'(w_eff);
      r_tail  <= r_tail + PW'(w_push);
      r_count <= r_count + CW'(w_push) - CW'(w_eff);
      if (w_acc)
        r_pend <= 2'd0;
      if (w_over)
        r_under <= 1'b1;
    end
  end

  always_comb begin
    logic [PW-1:0] v_idx;
    v_idx    = '0;
    o_window = '0;
    for (int i = 0; i < 8; i++) begin
      v_idx = r_head + PW'(i);
      if (4'(i) < w_wcnt)
        o_window[i] = r_buf[v_idx];
    end
  end

  assign o_window_count = w_wcnt;
  assign o_count        = r_count;
  assign o_underrun     = r_under;

endmodule
